// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared constants and helpers for the shared multiplier
package mult_pkg;

    localparam int MULT_N_DEFAULT = 9;

    // Requester-id width; a single requester still gets a 1-bit id.
    function automatic int id_width(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/mult_share_arb_rr_arbiter.sv
// rtl/mult_share_arb_rr_arbiter.sv - round-robin arbiter with one-hot grant
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id,
    output logic            grant_valid
);

    logic [IDW-1:0] ptr;
    logic [IDW:0]   cand;
    logic [IDW:0]   nxt;
    logic           found;

    // Search from ptr upward, wrapping at NREQ; first valid request wins.
    always_comb begin
        found    = 1'b0;
        grant_id = '0;
        cand     = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            if (!found && req[cand[IDW-1:0]]) begin
                found    = 1'b1;
                grant_id = cand[IDW-1:0];
            end
        end
    end

    assign grant_valid = en & found;

    always_comb begin
        grant = '0;
        if (grant_valid) begin
            grant[grant_id] = 1'b1;
        end
    end

    always_comb begin
        nxt = {1'b0, grant_id} + (IDW+1)'(1);
        if (nxt >= (IDW+1)'(NREQ)) begin
            nxt = '0;
        end
    end

    // The winner always has its request up, so grant_valid is an accepted transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (grant_valid) begin
            ptr <= nxt[IDW-1:0];
        end
    end

endmodule

// File: rtl/mult_share_arb.sv
// rtl/mult_share_arb.sv - round-robin shared N x N multiplier, two-stage pipe
module mult_share_arb
    import mult_pkg::*;
#(
    parameter int  N    = MULT_N_DEFAULT,
    parameter int  NREQ = 4,
    localparam int IDW  = id_width(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_x1,
    input  logic [NREQ*N-1:0] req_x2,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [2*N-1:0]    rsp_y,
    output logic [IDW-1:0]    rsp_id
);

    logic            stall;
    logic            adv;
    logic            xfer;
    logic [IDW-1:0]  win_id;
    logic [N-1:0]    sel_x1;
    logic [N-1:0]    sel_x2;

    logic            s1_valid;
    logic [N-1:0]    s1_x1;
    logic [N-1:0]    s1_x2;
    logic [IDW-1:0]  s1_id;
    logic            s2_valid;
    logic [2*N-1:0]  prod;

    assign stall     = s2_valid & ~rsp_ready;
    assign adv       = ~stall;
    assign rsp_valid = s2_valid;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req_valid),
        .en          (adv & rst_n),
        .grant       (req_ready),
        .grant_id    (win_id),
        .grant_valid (xfer)
    );

    always_comb begin
        sel_x1 = '0;
        sel_x2 = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_id == IDW'(i)) begin
                sel_x1 = req_x1[i*N +: N];
                sel_x2 = req_x2[i*N +: N];
            end
        end
    end

    // Zero-extend before multiplying so the full 2N-bit product is kept.
    assign prod = {{N{1'b0}}, s1_x1} * {{N{1'b0}}, s1_x2};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_x1    <= '0;
            s1_x2    <= '0;
            s1_id    <= '0;
            s2_valid <= 1'b0;
            rsp_y    <= '0;
            rsp_id   <= '0;
        end else if (adv) begin
            s1_valid <= xfer;
            if (xfer) begin
                s1_x1 <= sel_x1;
                s1_x2 <= sel_x2;
                s1_id <= win_id;
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                rsp_y  <= prod;
                rsp_id <= s1_id;
            end
        end
    end

endmodule

// File: tb/tb_mult_share_arb.sv
// tb/tb_mult_share_arb.sv - randomized scoreboard bench for mult_share_arb
module tb_mult_share_arb;

    localparam int N    = 9;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_x1;
    logic [NREQ*N-1:0] req_x2;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [2*N-1:0]    rsp_y;
    logic [IDW-1:0]    rsp_id;

    logic [N-1:0] x1 [NREQ];
    logic [N-1:0] x2 [NREQ];

    always #5 clk = ~clk;

    always_comb begin
        req_x1 = '0;
        req_x2 = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_x1[i*N +: N] = x1[i];
            req_x2[i*N +: N] = x2[i];
        end
    end

    mult_share_arb #(.N(N), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x1    (req_x1),
        .req_x2    (req_x2),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_id    (rsp_id)
    );

    typedef struct {
        int unsigned y;
        int unsigned id;
    } rsp_t;

    rsp_t            sb[$];
    int              checks = 0;
    int              errors = 0;
    int              mptr = 0;
    bit              m_s1 = 1'b0;
    bit              m_out = 1'b0;
    bit              m_rst_edge = 1'b1;
    logic [NREQ-1:0] acc = '0;
    bit              held_v = 1'b0;
    logic [31:0]     held_y;
    logic [31:0]     held_id;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: grant rule, pipeline occupancy and expected products.
    always @(negedge clk) begin
        logic [NREQ-1:0] exp_g;
        bit              stall;
        int              w;
        int              idx;
        int unsigned     p;
        exp_g = '0;
        w     = -1;
        stall = m_out && !rsp_ready;
        if (rst_n && !stall) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (mptr + k) % NREQ;
                if (w < 0 && req_valid[idx]) w = idx;
            end
        end
        if (w >= 0) exp_g[w] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_g));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_out));
        if (m_rst_edge) begin
            chk("reset_rsp_y", 32'(rsp_y), 32'd0);
            chk("reset_rsp_id", 32'(rsp_id), 32'd0);
        end
        acc = req_valid & req_ready;
        if (!rst_n) begin
            m_s1  = 1'b0;
            m_out = 1'b0;
            mptr  = 0;
            sb.delete();
        end else if (!stall) begin
            m_out = m_s1;
            m_s1  = (w >= 0);
            if (w >= 0) begin
                p = int'(x1[w]) * int'(x2[w]);
                sb.push_back('{y: p, id: w});
                mptr = (w + 1) % NREQ;
            end
        end
        m_rst_edge = !rst_n;
    end

    // Monitor: pops the scoreboard on every response handshake.
    always @(negedge clk) begin
        rsp_t e;
        if (held_v) begin
            chk("stall_hold_y", 32'(rsp_y), held_y);
            chk("stall_hold_id", 32'(rsp_id), held_id);
        end
        held_v = 1'b0;
        if (rst_n && rsp_valid === 1'b1) begin
            if (rsp_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got y=0x%0h id=%0d, expected no response", rsp_y, rsp_id);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_y", 32'(rsp_y), e.y);
                    chk("rsp_id", 32'(rsp_id), e.id);
                end
            end else begin
                held_v  = 1'b1;
                held_y  = 32'(rsp_y);
                held_id = 32'(rsp_id);
            end
        end
    end

    // Advance one cycle; accepted requests drop unless keep is set.
    task automatic step(input bit keep);
        @(posedge clk);
        #1;
        if (!keep) req_valid = req_valid & ~acc;
    endtask

    task automatic wait_idle(input string nm, input int limit);
        int n = 0;
        while (req_valid != '0 && n < limit) begin
            step(1'b0);
            n++;
        end
        if (req_valid != '0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got req_valid=0x%0h, expected 0x0", nm, req_valid);
            req_valid = '0;
        end
    endtask

    function automatic logic [N-1:0] rand_op();
        int r = $urandom_range(0, 7);
        if (r == 0) return '0;
        if (r == 1) return '1;
        return N'($urandom_range(0, (1 << N) - 1));
    endfunction

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            x1[i] = '0;
            x2[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        x1[0] = 9'd3;
        x2[0] = 9'd5;
        req_valid = 4'b0001;
        wait_idle("single", 10);
        repeat (3) step(1'b0);

        for (int i = 0; i < NREQ; i++) begin
            x1[i] = N'(i + 1);
            x2[i] = 9'd10;
        end
        req_valid = 4'b1111;
        repeat (12) step(1'b1);

        rsp_ready = 1'b0;
        repeat (5) step(1'b1);
        rsp_ready = 1'b1;
        repeat (4) step(1'b1);
        req_valid = '0;
        repeat (4) step(1'b0);

        x1[1] = 9'd511;
        x2[1] = 9'd511;
        x1[2] = 9'd0;
        x2[2] = 9'd511;
        req_valid = 4'b0110;
        wait_idle("width", 10);
        repeat (3) step(1'b0);

        for (int c = 0; c < 400; c++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                    x1[i] = rand_op();
                    x2[i] = rand_op();
                    req_valid[i] = 1'b1;
                end
            end
            step(1'b0);
        end

        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            x1[i] = rand_op();
            x2[i] = rand_op();
        end
        req_valid = 4'b1111;
        repeat (2) step(1'b1);
        rst_n = 1'b0;
        step(1'b1);
        rst_n = 1'b1;
        repeat (6) step(1'b1);

        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (6) step(1'b0);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
